dcache_controller: RTL and testbench
====================================

Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache between the pipeline MEM stage and the 16 KB line-organised data memory.
- Serves 32-bit CPU loads and stores from 32 lines of 256 bits each.
- Stalls the pipeline on a miss and runs writeback and refill over the data memory's enable/write/ack handshake.

Parameters:
- LINES, 32, number of cache lines; index width = log2(LINES) = 5.
- LINE_BITS, 256, line width; 32 bytes per line, 5-bit byte offset.
- TAG_BITS, 22, address bits [31:10].

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- p1_addr_i  in  32  CPU byte address; bits [1:0] ignored
- p1_data_i  in  32  store data
- p1_MemRead_i  in  1  load request
- p1_MemWrite_i  in  1  store request; wins if both request inputs are high
- p1_data_o  out  32  load data, valid when request high and stall low
- p1_stall_o  out  1  pipeline stall
- mem_addr_o  out  32  line address to data memory; bits [4:0] always 0
- mem_data_o  out  256  writeback line
- mem_enable_o  out  1  memory transaction request
- mem_write_o  out  1  1 = writeback, 0 = refill
- mem_data_i  in  256  refill line
- mem_ack_i  in  1  one-cycle memory completion pulse

Behaviour:
- Reset (rst_i low, asynchronous):
  - State goes to IDLE.
  - All valid and dirty bits clear.
  - mem_enable_o, mem_write_o, p1_stall_o and p1_data_o are 0.
  - Data and tag array contents are don't-care.
- Address split: offset = [4:0], word select = [4:2], index = [9:5], tag = [31:10].
  - Word w occupies line bits [32w+31:32w].
- Hit = request && valid[index] && tag match. It is combinational in IDLE only.
- States: IDLE, MISS, WRITEBACK, READMISS, READMISSOK.
- IDLE:
  - Read hit: p1_data_o = selected word in the same cycle; stall low.
  - Write hit: the word is merged into the line at the clock edge and dirty is set; stall low.
  - Miss: stall high; go to MISS.
  - No request: stall low; state holds.
- MISS: stall high. Go to WRITEBACK if the victim is valid and dirty, else go to READMISS.
- WRITEBACK:
  - mem_enable_o = 1, mem_write_o = 1.
  - mem_addr_o = {victim tag, index, 5'b0}; mem_data_o = victim line.
  - All held stable until ack.
  - On mem_ack_i, go to READMISS.
- READMISS:
  - mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {request tag, index, 5'b0}.
  - On mem_ack_i, go to READMISSOK.
- READMISSOK:
  - mem_enable_o = 0.
  - The data memory presents the line one cycle after its ack, so mem_data_i is sampled here.
  - Write line, tag, valid = 1, dirty = 0; go to IDLE.
- After refill, IDLE re-evaluates the request as a hit. Stores merge only then, never into the refill itself.
- mem_enable_o is a decode of state, so it is 0 in the cycle after every ack. This prevents a spurious back-to-back memory transaction.
  - WRITEBACK to READMISS is the exception: enable stays high, but write drops to 0 and the address changes.
- Memory latency is arbitrary (≥1 cycle). With the current 8-cycle memory, stall lasts 12 cycles for a clean miss and 21 cycles for a dirty miss.
- The CPU holds address, data and request while stalled.
  - If the request drops mid-miss, the fill still completes and the state returns to IDLE with stall low.
- Reset mid-transaction aborts immediately. The line is not installed and no write is retried.
- mem_ack_i outside WRITEBACK/READMISS is ignored.

Decomposition:
- Package dcache_pkg holds:
  - OFFSET_W = 5, INDEX_W = 5, TAG_W = 22, LINE_W = 256;
  - state enum (3-bit encoding);
  - tag-entry struct {valid, dirty, tag}.
- Sub-module dcache_sram holds the 32-entry tag array and data array.
  - Asynchronous read; synchronous write with a single write port.
  - Valid/dirty bits are kept in flops so reset clears them.

Test Plan:
- Cold read 0x0000_0040 → stall high 12 cycles; mem_enable_o with write = 0 and addr 0x40. The returned line has word 0 = 0x1111_1111, and p1_data_o = 0x1111_1111 in cycle 12.
- Read 0x0000_0044 immediately after → hit, stall 0 cycles, p1_data_o = line word 1.
- Write 0xDEAD_BEEF to 0x0000_0048 (hit) → no stall, no memory traffic. A later read of 0x48 returns 0xDEAD_BEEF.
- Read 0x0000_0440 (same index 2, new tag) → WRITEBACK to addr 0x40 with bits [95:64] = 0xDEAD_BEEF, then refill from 0x440. Stall is 21 cycles.
- Assert rst_i low during READMISS → stall, enable and write go 0 at once. A re-read of 0x440 misses again as a clean miss (no writeback).
- Both p1_MemRead_i and p1_MemWrite_i high on a hit → treated as a store; dirty set, and the line is written back on the next conflict.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped L1 data cache.
package dcache_pkg;
  localparam int OFFSET_W = 5;
  localparam int INDEX_W  = 5;
  localparam int TAG_W    = 22;
  localparam int LINE_W   = 256;
  localparam int LINES    = 1 << INDEX_W;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_MISS       = 3'd1,
    ST_WRITEBACK  = 3'd2,
    ST_READMISS   = 3'd3,
    ST_READMISSOK = 3'd4
  } state_e;

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } tag_entry_t;

  function automatic logic [LINE_W-1:0] merge_word(input logic [LINE_W-1:0] line,
                                                   input logic [2:0]        sel,
                                                   input logic [31:0]       word);
    logic [LINE_W-1:0] res;
    res = line;
    res[{sel, 5'b0} +: 32] = word;
    return res;
  endfunction
endpackage

// File: rtl/dcache_sram.sv
// Tag and data arrays: asynchronous read, single synchronous write port.
// Valid/dirty live in resettable flops; tag and data contents are don't-care after reset.
module dcache_sram
  import dcache_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [INDEX_W-1:0] index,
  output tag_entry_t         rd_entry,
  output logic [LINE_W-1:0]  rd_line,
  input  logic               we,
  input  tag_entry_t         wr_entry,
  input  logic [LINE_W-1:0]  wr_line
);
  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [LINE_W-1:0] data_mem [LINES];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we) begin
      valid_q[index] <= wr_entry.valid;
      dirty_q[index] <= wr_entry.dirty;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we) begin
      tag_mem[index]  <= wr_entry.tag;
      data_mem[index] <= wr_line;
    end
  end

  assign rd_entry = '{valid: valid_q[index], dirty: dirty_q[index], tag: tag_mem[index]};
  assign rd_line  = data_mem[index];
endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate L1 data cache controller.
//  state         | meaning
//  ST_IDLE       | serve hits combinationally, detect misses
//  ST_MISS       | choose writeback or refill from victim status
//  ST_WRITEBACK  | write the dirty victim line to memory
//  ST_READMISS   | request the missing line
//  ST_READMISSOK | install the line memory presents one cycle after ack
module dcache_controller
  import dcache_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       p1_addr_i,
  input  logic [31:0]       p1_data_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [31:0]       p1_data_o,
  output logic              p1_stall_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);
  state_e             state_q, state_d;
  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   req_tag;
  logic [2:0]         word_sel;
  logic               req, hit, we;
  tag_entry_t         rd_entry, wr_entry;
  logic [LINE_W-1:0]  rd_line, wr_line;
  logic               addr_unused;

  assign index       = p1_addr_i[OFFSET_W +: INDEX_W];
  assign req_tag     = p1_addr_i[31 -: TAG_W];
  assign word_sel    = p1_addr_i[4:2];
  assign addr_unused = ^p1_addr_i[1:0];
  assign req         = p1_MemRead_i | p1_MemWrite_i;
  assign hit         = (state_q == ST_IDLE) && req && rd_entry.valid && (rd_entry.tag == req_tag);

  dcache_sram u_sram (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .index    (index),
    .rd_entry (rd_entry),
    .rd_line  (rd_line),
    .we       (we),
    .wr_entry (wr_entry),
    .wr_line  (wr_line)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    p1_data_o    = '0;
    p1_stall_o   = 1'b0;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = {req_tag, index, 5'b0};
    mem_data_o   = rd_line;
    we           = 1'b0;
    wr_entry     = rd_entry;
    wr_line      = rd_line;
    case (state_q)
      ST_IDLE: begin
        if (hit) begin
          p1_data_o = rd_line[{word_sel, 5'b0} +: 32];
          if (p1_MemWrite_i) begin
            we       = 1'b1;
            wr_entry = '{valid: 1'b1, dirty: 1'b1, tag: req_tag};
            wr_line  = merge_word(rd_line, word_sel, p1_data_i);
          end
        end else if (req) begin
          p1_stall_o = 1'b1;
          state_d    = ST_MISS;
        end
      end
      ST_MISS: begin
        p1_stall_o = 1'b1;
        state_d    = (rd_entry.valid && rd_entry.dirty) ? ST_WRITEBACK : ST_READMISS;
      end
      ST_WRITEBACK: begin
        p1_stall_o   = 1'b1;
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {rd_entry.tag, index, 5'b0};
        if (mem_ack_i) state_d = ST_READMISS;
      end
      ST_READMISS: begin
        p1_stall_o   = 1'b1;
        mem_enable_o = 1'b1;
        if (mem_ack_i) state_d = ST_READMISSOK;
      end
      ST_READMISSOK: begin
        // refill installs clean; a pending store merges on the following IDLE hit
        p1_stall_o = 1'b1;
        we         = 1'b1;
        wr_entry   = '{valid: 1'b1, dirty: 1'b0, tag: req_tag};
        wr_line    = mem_data_i;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (!rst_i) p1_stall_o = 1'b0;
  end
endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: line-memory model plus an abstract cache/memory reference.
module tb_dcache_controller;
  localparam int MEM_LAT = 8;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic [31:0]  p1_addr_i = '0, p1_data_i = '0;
  logic         p1_MemRead_i = 1'b0, p1_MemWrite_i = 1'b0;
  logic [31:0]  p1_data_o, mem_addr_o;
  logic         p1_stall_o, mem_enable_o, mem_write_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i = '0;
  logic         mem_ack_i = 1'b0;

  int checks = 0, errors = 0;

  always #5 clk_i = ~clk_i;

  dcache_controller dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .p1_addr_i    (p1_addr_i),
    .p1_data_i    (p1_data_i),
    .p1_MemRead_i (p1_MemRead_i),
    .p1_MemWrite_i(p1_MemWrite_i),
    .p1_data_o    (p1_data_o),
    .p1_stall_o   (p1_stall_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_data_i   (mem_data_i),
    .mem_ack_i    (mem_ack_i)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] init_line(input logic [31:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++)
      l[w*32 +: 32] = (la == 32'h40) ? 32'h1111_1111 * (w + 1)
                                     : (la * 32'h9E37_79B9) ^ (32'h0101_0101 * w) ^ 32'h5A5A_0000;
    return l;
  endfunction

  // environment: line memory answering the enable/write/ack handshake
  logic [255:0] bmem [logic [31:0]];
  int           wb_cnt = 0, rd_cnt = 0;
  logic [31:0]  wb_addr = '0, rd_addr = '0;
  logic [255:0] wb_data = '0;

  initial begin
    int  mcnt;
    bit  acked, acked_write, en, wr;
    logic [31:0] a;
    mcnt = 0;
    acked_write = 0;
    forever begin
      @(posedge clk_i or negedge rst_i);
      if (!rst_i) begin
        mcnt = 0;
        mem_ack_i <= 1'b0;
      end else begin
        acked = mem_ack_i;
        en = mem_enable_o;
        wr = mem_write_o;
        a  = mem_addr_o;
        mem_ack_i <= 1'b0;
        if (en && !acked) begin
          if (mcnt == MEM_LAT - 1) begin
            mcnt = 0;
            mem_ack_i <= 1'b1;
            acked_write = wr;
            if (wr) begin
              bmem[a] = mem_data_o;
              wb_cnt++;
              wb_addr = a;
              wb_data = mem_data_o;
            end else begin
              mem_data_i <= bmem.exists(a) ? bmem[a] : init_line(a);
              rd_cnt++;
              rd_addr = a;
            end
          end else mcnt++;
        end
        if (acked) begin
          #1;
          if (acked_write) check("write_drops_after_wb_ack", mem_write_o, 1'b0);
          else             check("enable_drops_after_rd_ack", mem_enable_o, 1'b0);
        end
      end
    end
  end

  // reference: architectural memory image and abstract cache contents
  logic [255:0] ref_mem [logic [31:0]];
  bit           mvalid [32];
  bit           mdirty [32];
  logic [21:0]  mtag   [32];
  logic [255:0] mdata  [32];

  function automatic logic [255:0] ref_line(input logic [31:0] la);
    return ref_mem.exists(la) ? ref_mem[la] : init_line(la);
  endfunction

  task automatic access(input logic [31:0] addr, input bit rd, input bit wr,
                        input logic [31:0] wdata, output logic [31:0] rdata);
    int          idx, w, n, wb0, rd0;
    logic [21:0] t;
    logic [31:0] victim;
    bit          miss, dirty_victim;
    idx = int'(addr[9:5]);
    w   = int'(addr[4:2]);
    t   = addr[31:10];
    miss         = !(mvalid[idx] && mtag[idx] == t);
    dirty_victim = miss && mvalid[idx] && mdirty[idx];
    victim       = {mtag[idx], addr[9:5], 5'b0};
    wb0 = wb_cnt;
    rd0 = rd_cnt;
    @(negedge clk_i);
    p1_addr_i = addr; p1_data_i = wdata;
    p1_MemRead_i = rd; p1_MemWrite_i = wr;
    #1;
    n = 0;
    while (p1_stall_o && n < 100) begin
      @(negedge clk_i); #1;
      n++;
    end
    check("stall_cycles", n, !miss ? 0 : (dirty_victim ? 21 : 12));
    check("writebacks", wb_cnt - wb0, dirty_victim ? 1 : 0);
    check("refills", rd_cnt - rd0, miss ? 1 : 0);
    if (dirty_victim) begin
      check("wb_addr", wb_addr, victim);
      check("wb_data", wb_data, mdata[idx]);
      ref_mem[victim] = mdata[idx];
    end
    if (miss) begin
      check("refill_addr", rd_addr, {addr[31:5], 5'b0});
      mvalid[idx] = 1; mdirty[idx] = 0; mtag[idx] = t;
      mdata[idx]  = ref_line({addr[31:5], 5'b0});
    end
    rdata = p1_data_o;
    if (wr) begin
      mdata[idx][w*32 +: 32] = wdata;
      mdirty[idx] = 1;
    end else if (rd) begin
      check("load_data", p1_data_o, mdata[idx][w*32 +: 32]);
    end
    @(posedge clk_i); #1;
    p1_MemRead_i = 0; p1_MemWrite_i = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rdata;
    int          n;
    bit          found;
    for (int i = 0; i < 32; i++) begin mvalid[i] = 0; mdirty[i] = 0; mtag[i] = '0; mdata[i] = '0; end

    #2;
    check("rst_stall", p1_stall_o, 1'b0);
    check("rst_enable", mem_enable_o, 1'b0);
    check("rst_write", mem_write_o, 1'b0);
    check("rst_data", p1_data_o, 32'h0);
    @(negedge clk_i); rst_i = 1;

    access(32'h0000_0040, 1, 0, 0, rdata);
    check("cold_word0", rdata, 32'h1111_1111);
    access(32'h0000_0044, 1, 0, 0, rdata);
    check("hit_word1", rdata, 32'h2222_2222);
    access(32'h0000_0048, 0, 1, 32'hDEAD_BEEF, rdata);
    access(32'h0000_0048, 1, 0, 0, rdata);
    check("store_readback", rdata, 32'hDEAD_BEEF);
    access(32'h0000_0440, 1, 0, 0, rdata);
    check("wb_victim_addr", wb_addr, 32'h0000_0040);
    check("wb_word2", wb_data[95:64], 32'hDEAD_BEEF);

    // both request lines high on a hit acts as a store
    access(32'h0000_0444, 1, 1, 32'hCAFE_F00D, rdata);
    access(32'h0000_0040, 1, 0, 0, rdata);
    check("both_store_written_back", wb_data[63:32], 32'hCAFE_F00D);

    // reset while a refill is outstanding
    @(negedge clk_i);
    p1_addr_i = 32'h0000_0840; p1_MemRead_i = 1;
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk_i); #1;
      found = mem_enable_o && !mem_write_o;
    end
    check("reach_readmiss", found, 1'b1);
    repeat (3) @(negedge clk_i);
    rst_i = 0;
    #1;
    check("abort_stall", p1_stall_o, 1'b0);
    check("abort_enable", mem_enable_o, 1'b0);
    check("abort_write", mem_write_o, 1'b0);
    p1_MemRead_i = 0;
    @(negedge clk_i); rst_i = 1;
    for (int i = 0; i < 32; i++) begin mvalid[i] = 0; mdirty[i] = 0; end
    access(32'h0000_0440, 1, 0, 0, rdata);

    // request withdrawn mid-miss: fill still completes
    begin
      int rd0;
      rd0 = rd_cnt;
      @(negedge clk_i);
      p1_addr_i = 32'h0000_0C60; p1_MemRead_i = 1;
      repeat (3) @(negedge clk_i);
      p1_MemRead_i = 0;
      #1;
      n = 0;
      while (p1_stall_o && n < 40) begin @(negedge clk_i); #1; n++; end
      check("drop_stall_released", p1_stall_o, 1'b0);
      repeat (2) @(negedge clk_i);
      check("drop_refill_done", rd_cnt - rd0, 1);
      mvalid[3] = 1; mdirty[3] = 0; mtag[3] = 22'd3; mdata[3] = ref_line(32'h0000_0C60);
      access(32'h0000_0C60, 1, 0, 0, rdata);
    end

    for (int k = 0; k < 300; k++) begin
      logic [31:0] a;
      int          op;
      a  = {20'(0), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), 5'($urandom)};
      op = $urandom_range(0, 3);
      access(a, op != 2, op >= 2, $urandom, rdata);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
